rx_packet_scheduler: RTL
========================

// Module: rx_packet_scheduler
// PURPOSE
// Round-robin scheduler that decides which RX channel FIFO the packet builder drains next.
// Sits between the per-channel RX FIFOs and packet_builder, and tracks per-channel overrun.
// Grants one packet at a time and holds the grant until the builder reports completion.
// Index 0 is the command/status channel (header chan 5'h1f); index i>0 is data channel i-1.
// PARAMETERS
// NUM_CHAN       2     number of data channels; requesters are indices 0..NUM_CHAN
// PKT_WORDS      504   FIFO fill level (16-bit words) that makes a channel ready
// FLUSH_TIMEOUT  4096  idle rxclk cycles before partially filled FIFOs become ready
// PORTS
// rxclk          in   1                 RX clock; all state on posedge
// reset          in   1                 asynchronous, active-high
// channels       in   4                 highest enabled requester index; runtime, <= NUM_CHAN
// chan_empty     in   NUM_CHAN+1        per-requester FIFO empty
// chan_usedw     in   10*(NUM_CHAN+1)   per-requester fill level, requester i at [10i+9:10i]
// have_space     in   1                 USB-side FIFO can take one full packet
// grant_valid    out  1                 grant offered to the builder
// grant_sel      out  4                 granted requester index, drives FIFO read mux
// grant_chan     out  5                 header channel field: 5'h1f for idx 0, else idx-1
// grant_overrun  out  1                 sticky overrun of the granted requester, for header
// grant_ack      in   1                 builder accepted the grant (starts HEADER1)
// pkt_done       in   1                 builder finished the packet (1-cycle pulse)
// overrun        out  NUM_CHAN+1        sticky per-requester overrun flags
// debugbus       out  8                 {state[1:0], grant_sel[2:0], flush_mode, have_space, grant_valid}
// BEHAVIOUR
// Reset (async): state=SCAN, grant_valid=0, grant_sel=0, grant_chan=5'h1f, grant_overrun=0,
//   overrun=0, last_grant=channels-index wrap point 0, idle_cnt=0, flush_mode=0.
// ready[i] = ~chan_empty[i] && (usedw[i]>=PKT_WORDS || i==0 || flush_mode); only i<=channels.
// States:
//  SCAN: pick first ready i searching last_grant+1 .. channels, wrapping to 0 (one cycle,
//    combinational). If found and have_space: register grant_sel/chan/overrun, grant_valid<=1,
//    -> GRANT (grant visible one cycle after ready+space seen). If found and ~have_space:
//    set overrun[i] for every ready i>0, stay SCAN. None found: stay SCAN.
//  GRANT: hold outputs stable. On grant_ack: grant_valid<=0, last_grant<=grant_sel,
//    overrun[grant_sel]<=0, -> BUSY. have_space dropping here does not revoke the grant.
//  BUSY: wait for pkt_done, -> HOLD. Grant outputs stay stable until HOLD ends.
//  HOLD: one cycle gap so builder empties/usedw settle, -> SCAN.
// pkt_done outside BUSY and grant_ack outside GRANT are ignored.
// Overrun set and clear on the same requester same cycle: clear wins (flag already reported).
// idle_cnt: increments each SCAN cycle with no grant, saturates at FLUSH_TIMEOUT; any grant
//   clears it. At FLUSH_TIMEOUT flush_mode<=1; flush_mode clears after one grant or after a
//   full wrap with nothing ready. Width = clog2(FLUSH_TIMEOUT+1).
// channels reduced below last_grant: search wraps to 0 next SCAN; grant in flight completes.
// Index >channels never granted, never sets overrun.
// STRUCTURE
// Shared package rx_pkt_defs: state encodings, CTRL_CHAN_ID 5'h1f, PKT_WORDS default,
//   usedw width 10, header field positions used by the builder.
// One sub-module rr_pick (ready vector, start index, limit -> found, index), combinational.
// TESTING
// Ch1 usedw=504, have_space=1 -> grant_valid next cycle, grant_sel=2, grant_chan=1.
// Ch0..2 all ready, last_grant=0 -> successive grants 1,2,0,1 with ack/pkt_done each time.
// Ch2 ready, have_space=0 for 10 cycles -> overrun[2]=1; then space -> grant_overrun=1,
//   overrun[2]=0 after grant_ack.
// Ch1 usedw=100 only, idle 4096 cycles -> flush_mode=1, grant sel=2; flush_mode=0 after ack.
// Reset asserted during BUSY -> all outputs to reset values same cycle, SCAN afterwards.
// channels=1, ch2 full -> never granted, overrun[2] stays 0.

Source files
------------

// File: rtl/rx_pkt_defs.sv
// Shared definitions for the RX packet path: scheduler state encodings, the
// control-channel header ID and the header field layout used by packet_builder.
package rx_pkt_defs;

  localparam logic [1:0] ST_SCAN  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [4:0]  CTRL_CHAN_ID    = 5'h1f;
  localparam int unsigned PKT_WORDS_DEF   = 504;
  localparam int unsigned USEDW_W         = 10;
  localparam int unsigned HDR_OVERRUN_BIT = 15;
  localparam int unsigned HDR_CHAN_LSB    = 8;
  localparam int unsigned HDR_CHAN_W      = 5;

  // Requester 0 is the command/status channel; data requesters are offset by one.
  function automatic logic [4:0] hdr_chan(input logic [3:0] idx);
    return (idx == 4'd0) ? CTRL_CHAN_ID : {1'b0, idx - 4'd1};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first ready index above i_start (up to
// i_limit), otherwise the lowest ready index at or below i_limit.
module rr_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] i_ready,
  input  logic [3:0]   i_start,
  input  logic [3:0]   i_limit,
  output logic         o_found,
  output logic [3:0]   o_idx
);

  logic       w_hi_found;
  logic [3:0] w_hi_idx;
  logic       w_lo_found;
  logic [3:0] w_lo_idx;

  // Descending scan so the last hit written is the lowest matching index.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = 4'd0;
    w_lo_found = 1'b0;
    w_lo_idx   = 4'd0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_ready[i] && (4'(i) <= i_limit)) begin
        w_lo_found = 1'b1;
        w_lo_idx   = 4'(i);
        if (4'(i) > i_start) begin
          w_hi_found = 1'b1;
          w_hi_idx   = 4'(i);
        end
      end
    end
    o_found = w_lo_found;
    o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/rx_packet_scheduler.sv
// Round-robin grant of RX channel FIFOs to packet_builder, one packet at a time,
// with sticky per-channel overrun tracking and an idle flush of partial FIFOs.
module rx_packet_scheduler
  import rx_pkt_defs::*;
#(
  parameter int unsigned NUM_CHAN      = 2,
  parameter int unsigned PKT_WORDS     = PKT_WORDS_DEF,
  parameter int unsigned FLUSH_TIMEOUT = 4096
) (
  input  logic                            rxclk,
  input  logic                            reset,
  input  logic [3:0]                      channels,
  input  logic [NUM_CHAN:0]               chan_empty,
  input  logic [USEDW_W*(NUM_CHAN+1)-1:0] chan_usedw,
  input  logic                            have_space,
  output logic                            grant_valid,
  output logic [3:0]                      grant_sel,
  output logic [4:0]                      grant_chan,
  output logic                            grant_overrun,
  input  logic                            grant_ack,
  input  logic                            pkt_done,
  output logic [NUM_CHAN:0]               overrun,
  output logic [7:0]                      debugbus
);

  localparam int unsigned N  = NUM_CHAN + 1;
  localparam int unsigned CW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [USEDW_W-1:0] PKT_LVL  = PKT_WORDS[USEDW_W-1:0];
  localparam logic [CW-1:0]      IDLE_MAX = FLUSH_TIMEOUT[CW-1:0];

  logic [1:0]    r_state;
  logic          r_valid;
  logic [3:0]    r_sel;
  logic [4:0]    r_chan;
  logic          r_govr;
  logic [N-1:0]  r_overrun;
  logic [3:0]    r_last;
  logic [CW-1:0] r_idle;
  logic          r_flush;

  logic [N-1:0]  w_ready;
  logic          w_found;
  logic [3:0]    w_idx;
  logic          w_pick_ovr;
  logic [N-1:0]  w_sel_oh;
  logic [N-1:0]  w_ovr_set;
  logic [N-1:0]  w_ovr_clr;
  logic          w_take;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_ready[i] = ~chan_empty[i] && (4'(i) <= channels) &&
                   ((chan_usedw[USEDW_W*i +: USEDW_W] >= PKT_LVL) || (i == 0) || r_flush);
    end
  end

  rr_pick #(
    .N (N)
  ) u_rr_pick (
    .i_ready (w_ready),
    .i_start (r_last),
    .i_limit (channels),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_pick_ovr = 1'b0;
    w_sel_oh   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (4'(i) == w_idx) w_pick_ovr = r_overrun[i];
      if (4'(i) == r_sel) w_sel_oh[i] = 1'b1;
    end
  end

  assign w_take    = (r_state == ST_SCAN) && w_found && have_space;
  // Only data requesters can overrun; the control channel is always drained.
  assign w_ovr_set = ((r_state == ST_SCAN) && w_found && !have_space) ?
                     {w_ready[N-1:1], 1'b0} : '0;
  assign w_ovr_clr = ((r_state == ST_GRANT) && grant_ack) ? w_sel_oh : '0;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_SCAN;
      r_valid   <= 1'b0;
      r_sel     <= 4'd0;
      r_chan    <= CTRL_CHAN_ID;
      r_govr    <= 1'b0;
      r_overrun <= '0;
      r_last    <= 4'd0;
      r_idle    <= '0;
      r_flush   <= 1'b0;
    end else begin
      // Clear wins: the flag has already been reported in the grant header.
      r_overrun <= (r_overrun | w_ovr_set) & ~w_ovr_clr;
      case (r_state)
        ST_SCAN: begin
          if (w_take) begin
            r_sel   <= w_idx;
            r_chan  <= hdr_chan(w_idx);
            r_govr  <= w_pick_ovr;
            r_valid <= 1'b1;
            r_idle  <= '0;
            r_state <= ST_GRANT;
          end else if (!w_found && r_flush) begin
            r_flush <= 1'b0;
            r_idle  <= '0;
          end else if (r_idle == IDLE_MAX) begin
            r_flush <= 1'b1;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        ST_GRANT: begin
          if (grant_ack) begin
            r_valid <= 1'b0;
            r_last  <= r_sel;
            r_flush <= 1'b0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (pkt_done) r_state <= ST_HOLD;
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign grant_valid   = r_valid;
  assign grant_sel     = r_sel;
  assign grant_chan    = r_chan;
  assign grant_overrun = r_govr;
  assign overrun       = r_overrun;
  assign debugbus      = {r_state, r_sel[2:0], r_flush, have_space, r_valid};

endmodule
